// File: rtl/hps_reset_req_sequencer.sv
// Sequences cold/warm/debug reset requests into one-at-a-time fixed-width pulses towards the HPS.
// Define HPS_RST_PB_DEBOUNCE_EN to add the debounced pushbutton (short press = warm, long = cold).
module hps_reset_req_sequencer #(
  parameter int unsigned PULSE_CYCLES     = 16,
  parameter int unsigned ACK_TIMEOUT      = 50000000,
  parameter int unsigned HOLDOFF_CYCLES   = 1024,
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned LONGPRESS_CYCLES = 150000000
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic [2:0] req_in,
  input  logic       user_pb_n,
  input  logic       h2f_reset_n,
  output logic [2:0] hps_reset_req,
  output logic       busy,
  output logic [1:0] active_kind,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_ASSERT, ST_WAIT_LO, ST_WAIT_HI, ST_HOLDOFF} state_t;

  localparam logic [31:0] PULSE_LAST   = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] ACK_LAST     = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  req_q, pending, pb_set, req_set, grant_clr;
  logic [1:0]  kind, grant_kind;
  logic [31:0] cnt, to_cnt;
  logic        h2f_meta, h2f_sync, done_r, err_r, ack_timeout, take;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      h2f_meta <= 1'b1;
      h2f_sync <= 1'b1;
    end else begin
      h2f_meta <= h2f_reset_n;
      h2f_sync <= h2f_meta;
    end
  end

`ifdef HPS_RST_PB_DEBOUNCE_EN
  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONGPRESS_CYCLES - 1);

  logic        pb_meta, pb_sync, pb_db, long_fired, pb_cold, pb_warm;
  logic [31:0] db_cnt, press_cnt;

  // pb_db is the debounced "pressed" level; a long press fires cold once and suppresses warm.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      pb_meta    <= 1'b1;
      pb_sync    <= 1'b1;
      pb_db      <= 1'b0;
      db_cnt     <= '0;
      press_cnt  <= '0;
      long_fired <= 1'b0;
      pb_cold    <= 1'b0;
      pb_warm    <= 1'b0;
    end else begin
      pb_meta <= user_pb_n;
      pb_sync <= pb_meta;
      pb_cold <= 1'b0;
      pb_warm <= 1'b0;
      if (~pb_sync != pb_db) begin
        if (db_cnt >= DEB_LAST) begin
          pb_db  <= ~pb_sync;
          db_cnt <= '0;
          if (pb_sync && !long_fired) pb_warm <= 1'b1;
        end else begin
          db_cnt <= db_cnt + 32'd1;
        end
      end else begin
        db_cnt <= '0;
      end
      if (pb_db) begin
        if (!long_fired) begin
          if (press_cnt >= LONG_LAST) begin
            pb_cold    <= 1'b1;
            long_fired <= 1'b1;
          end else begin
            press_cnt <= press_cnt + 32'd1;
          end
        end
      end else begin
        press_cnt  <= '0;
        long_fired <= 1'b0;
      end
    end
  end

  assign pb_set = {1'b0, pb_warm, pb_cold};
`else
  logic pb_unused;
  assign pb_unused = user_pb_n ^ (DEBOUNCE_CYCLES == 0) ^ (LONGPRESS_CYCLES == 0);
  assign pb_set    = 3'b000;
`endif

  assign req_set = (req_in & ~req_q) | pb_set;
  assign take    = (state == ST_IDLE) && (|pending);

  always_comb begin
    grant_kind = 2'd0;
    grant_clr  = 3'b000;
    if (pending[0]) begin
      grant_kind = 2'd1;
      grant_clr  = 3'b111;
    end else if (pending[1]) begin
      grant_kind = 2'd2;
      grant_clr  = 3'b010;
    end else if (pending[2]) begin
      grant_kind = 2'd3;
      grant_clr  = 3'b100;
    end
  end

  assign ack_timeout = (to_cnt >= ACK_LAST) &&
                       (((state == ST_WAIT_LO) && h2f_sync) || ((state == ST_WAIT_HI) && !h2f_sync));

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state <= ST_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (|pending) state_n = ST_ASSERT;
      ST_ASSERT:  if (cnt >= PULSE_LAST) state_n = ST_WAIT_LO;
      ST_WAIT_LO: if (!h2f_sync || ack_timeout) state_n = h2f_sync ? ST_HOLDOFF : ST_WAIT_HI;
      ST_WAIT_HI: if (h2f_sync || ack_timeout) state_n = ST_HOLDOFF;
      ST_HOLDOFF: if (cnt >= HOLDOFF_LAST) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // A new set wins over a same-cycle grant clear so that request is not lost.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      req_q   <= '0;
      pending <= '0;
      kind    <= 2'd0;
      cnt     <= '0;
      to_cnt  <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      req_q   <= req_in;
      pending <= (pending & ~(take ? grant_clr : 3'b000)) | req_set;
      if (take) kind <= grant_kind;
      cnt     <= (state != state_n) ? '0 : ((cnt == '1) ? cnt : cnt + 32'd1);
      if (state_n == ST_WAIT_LO && state != ST_WAIT_LO) to_cnt <= '0;
      else if (state == ST_WAIT_LO || state == ST_WAIT_HI) to_cnt <= (to_cnt == '1) ? to_cnt : to_cnt + 32'd1;
      else to_cnt <= '0;
      done_r  <= (state == ST_WAIT_HI) && h2f_sync;
      err_r   <= err_r | ack_timeout;
    end
  end

  always_comb begin
    hps_reset_req = 3'b000;
    if (state == ST_ASSERT) begin
      case (kind)
        2'd1:    hps_reset_req = 3'b001;
        2'd2:    hps_reset_req = 3'b010;
        2'd3:    hps_reset_req = 3'b100;
        default: hps_reset_req = 3'b000;
      endcase
    end
    busy        = (state != ST_IDLE);
    active_kind = busy ? kind : 2'd0;
    done        = done_r;
    timeout_err = err_r;
  end

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Scoreboard bench for hps_reset_req_sequencer: expected pulses are queued at stimulus time
// and popped when the DUT finishes each hps_reset_req pulse; an HPS model answers the handshake.
module tb_hps_reset_req_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic [2:0] req_in = 3'b000;
  logic       user_pb_n = 1'b1;
  logic       h2f_reset_n = 1'b1;
  logic [2:0] hps_reset_req;
  logic       busy;
  logic [1:0] active_kind;
  logic       done;
  logic       timeout_err;

  int         total_cnt = 0;
  int         bad_cnt = 0;
  int         done_cnt = 0;
  int         d0;
  int         exp_pb;
  logic [2:0] exp_q[$];
  logic       ack_en = 1'b1;
  logic       in_pulse = 1'b0;
  logic [2:0] pulse_bits;
  logic [2:0] pulse_exp;
  int         pulse_width = 0;
  int         ack_cnt = 0;

  hps_reset_req_sequencer #(
    .PULSE_CYCLES(4), .ACK_TIMEOUT(20), .HOLDOFF_CYCLES(8),
    .DEBOUNCE_CYCLES(4), .LONGPRESS_CYCLES(32)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .req_in(req_in), .user_pb_n(user_pb_n),
    .h2f_reset_n(h2f_reset_n), .hps_reset_req(hps_reset_req), .busy(busy),
    .active_kind(active_kind), .done(done), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total_cnt++;
    if (got !== expv) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input bit push, input logic [2:0] expv);
    if (push) exp_q.push_back(expv);
    req_in = r;
    tick();
    req_in = 3'b000;
  endtask

  task automatic pbLevel(input logic lvl, input int cycles);
    user_pb_n = lvl;
    repeat (cycles) tick();
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Pulse monitor, scoreboard pop and HPS handshake model.
  always @(negedge sys_clk) begin
    if (done === 1'b1) done_cnt++;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) h2f_reset_n = 1'b1;
    end
    if (sys_reset) begin
      in_pulse    = 1'b0;
      ack_cnt     = 0;
      h2f_reset_n = 1'b1;
    end else if (hps_reset_req != 3'b000) begin
      if (!in_pulse) begin
        in_pulse    = 1'b1;
        pulse_width = 0;
        pulse_bits  = 3'b000;
      end
      pulse_width++;
      pulse_bits = pulse_bits | hps_reset_req;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, pulse_bits}, 32'd0);
      end else begin
        pulse_exp = exp_q.pop_front();
        checkOutput("pulse_kind", {29'd0, pulse_bits}, {29'd0, pulse_exp});
        checkOutput("pulse_width", pulse_width, 32'd4);
      end
      if (ack_en) begin
        h2f_reset_n = 1'b0;
        ack_cnt     = 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) tick();
    checkOutput("rst_req", {29'd0, hps_reset_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_kind", {30'd0, active_kind}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, timeout_err}, 32'd0);
    sys_reset = 1'b0;
    repeat (2) tick();

    // Warm request: latency, width, done and holdoff length.
    d0 = done_cnt;
    applyStimulus(3'b010, 1'b1, 3'b010);
    checkOutput("lat_first", {29'd0, hps_reset_req}, 32'd0);
    tick();
    checkOutput("lat_second", {29'd0, hps_reset_req}, 32'b010);
    checkOutput("warm_kind", {30'd0, active_kind}, 32'd2);
    waitDone(100);
    checkOutput("holdoff_busy0", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    checkOutput("holdoff_busy7", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("holdoff_exit", {31'd0, busy}, 32'd0);
    checkOutput("warm_done_cnt", done_cnt - d0, 32'd1);

    // All three at once: only cold runs.
    applyStimulus(3'b111, 1'b1, 3'b001);
    tick();
    checkOutput("all_cold", {29'd0, hps_reset_req}, 32'b001);
    checkOutput("all_kind", {30'd0, active_kind}, 32'd1);
    waitIdle(100);
    repeat (5) tick();
    checkOutput("all_no_leftover", {31'd0, busy}, 32'd0);

    // Debug arriving during warm ASSERT is granted right after holdoff.
    applyStimulus(3'b010, 1'b1, 3'b010);
    tick();
    checkOutput("q_warm", {29'd0, hps_reset_req}, 32'b010);
    applyStimulus(3'b100, 1'b1, 3'b100);
    waitDone(100);
    repeat (8) tick();
    checkOutput("q_gap_idle", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("q_debug_next", {29'd0, hps_reset_req}, 32'b100);
    waitIdle(100);

    // No handshake: timeout 20 cycles after WAIT_LO entry, no done, sticky flag.
    ack_en = 1'b0;
    d0 = done_cnt;
    applyStimulus(3'b100, 1'b1, 3'b100);
    tick();
    checkOutput("to_assert", {29'd0, hps_reset_req}, 32'b100);
    repeat (23) tick();
    checkOutput("to_before", {31'd0, timeout_err}, 32'd0);
    tick();
    checkOutput("to_set", {31'd0, timeout_err}, 32'd1);
    waitIdle(100);
    checkOutput("to_sticky", {31'd0, timeout_err}, 32'd1);
    checkOutput("to_no_done", done_cnt - d0, 32'd0);
    ack_en = 1'b1;

    // Reset in ASSERT with a warm pending.
    applyStimulus(3'b001, 1'b0, 3'b000);
    tick();
    checkOutput("mr_assert", {29'd0, hps_reset_req}, 32'b001);
    applyStimulus(3'b010, 1'b0, 3'b000);
    #2 sys_reset = 1'b1;
    #1;
    checkOutput("mr_req", {29'd0, hps_reset_req}, 32'd0);
    checkOutput("mr_busy", {31'd0, busy}, 32'd0);
    checkOutput("mr_kind", {30'd0, active_kind}, 32'd0);
    checkOutput("mr_err", {31'd0, timeout_err}, 32'd0);
    tick();
    sys_reset = 1'b0;
    repeat (10) tick();
    checkOutput("mr_pending_cleared", {31'd0, busy}, 32'd0);

    // Pushbutton: glitchy short press then a long press.
`ifdef HPS_RST_PB_DEBOUNCE_EN
    exp_pb = 1;
    exp_q.push_back(3'b010);
`else
    exp_pb = 0;
`endif
    d0 = done_cnt;
    pbLevel(1'b0, 2);
    pbLevel(1'b1, 2);
    pbLevel(1'b0, 5);
    pbLevel(1'b1, 2);
    pbLevel(1'b0, 5);
    pbLevel(1'b1, 40);
    waitIdle(200);
    repeat (10) tick();
    checkOutput("pb_short_done", done_cnt - d0, exp_pb);
`ifdef HPS_RST_PB_DEBOUNCE_EN
    exp_q.push_back(3'b001);
`endif
    d0 = done_cnt;
    pbLevel(1'b0, 40);
    pbLevel(1'b1, 30);
    waitIdle(200);
    repeat (30) tick();
    checkOutput("pb_long_done", done_cnt - d0, exp_pb);
    checkOutput("pb_long_idle", {31'd0, busy}, 32'd0);

    checkOutput("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
